dadder_core: RTL and testbench

Datapath adder that is the producing end of the dadder data plane: it accepts operand pairs on the data-plane input handshake, computes their unsigned sum and drives results on the data-plane output handshake. The control plane sets the block's enable and overflow mode and exposes status. The block sits between the input and output agent interfaces in the dadder testbench. It is the design those interfaces and their assertion checker are bound to.

---
 rtl/dadder_core.sv | 122 ++++++++++++
 tb/tb_dadder_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dadder_core.sv
// rtl/dadder_core.sv - unsigned adder: one S1 register stage feeding a 2-entry output FIFO
// Optional saturation on overflow is built when DADDER_CORE_SAT_EN is defined.
module dadder_core #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cp_en,
  input  logic                  cp_sat,
  input  logic                  cp_clr,
  output logic                  cp_idle,
  output logic [CNT_WIDTH-1:0]  cp_count,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_sum,
  output logic                  out_ovf
);

  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic                  s1_ovf_q, s1_ovf_d;
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH-1:0] e0_sum_q, e0_sum_d, e1_sum_q, e1_sum_d;
  logic                  e0_ovf_q, e0_ovf_d, e1_ovf_q, e1_ovf_d;
  logic                  in_rdy_q, in_rdy_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [DATA_WIDTH:0]   full;
  logic [DATA_WIDTH-1:0] res_sum;
  logic                  res_ovf;
  logic                  accept, pop, move;
  logic [1:0]            cnt_after_pop, occ_d;

  assign full    = {1'b0, in_a} + {1'b0, in_b};
  assign res_ovf = full[DATA_WIDTH];
`ifdef DADDER_CORE_SAT_EN
  assign res_sum = (res_ovf & cp_sat) ? {DATA_WIDTH{1'b1}} : full[DATA_WIDTH-1:0];
`else
  logic unused_sat;
  assign unused_sat = cp_sat;
  assign res_sum    = full[DATA_WIDTH-1:0];
`endif

  assign accept        = in_vld & in_rdy_q;
  assign pop           = (fifo_cnt_q != 2'd0) & out_rdy;
  assign cnt_after_pop = fifo_cnt_q - {1'b0, pop};
  // S1 advances whenever the FIFO has a free slot once this cycle's pop is taken
  assign move          = s1_vld_q & (cnt_after_pop != 2'd2);

  always_comb begin
    s1_vld_d   = accept | (s1_vld_q & ~move);
    s1_sum_d   = accept ? res_sum : s1_sum_q;
    s1_ovf_d   = accept ? res_ovf : s1_ovf_q;
    fifo_cnt_d = cnt_after_pop + {1'b0, move};
    e0_sum_d   = e0_sum_q;
    e0_ovf_d   = e0_ovf_q;
    e1_sum_d   = e1_sum_q;
    e1_ovf_d   = e1_ovf_q;
    // Entry 0 is the head; it only changes when refilled, so out_sum holds when empty
    if (pop && (fifo_cnt_q == 2'd2)) begin
      e0_sum_d = e1_sum_q;
      e0_ovf_d = e1_ovf_q;
    end
    if (move) begin
      if (cnt_after_pop == 2'd0) begin
        e0_sum_d = s1_sum_q;
        e0_ovf_d = s1_ovf_q;
      end else begin
        e1_sum_d = s1_sum_q;
        e1_ovf_d = s1_ovf_q;
      end
    end
    occ_d    = fifo_cnt_d + {1'b0, s1_vld_d};
    in_rdy_d = cp_en & (occ_d != 2'd3);
    if (cp_clr) begin
      count_d = '0;
    end else if (pop) begin
      count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_sum_q   <= '0;
      s1_ovf_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      e0_sum_q   <= '0;
      e0_ovf_q   <= 1'b0;
      e1_sum_q   <= '0;
      e1_ovf_q   <= 1'b0;
      in_rdy_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_sum_q   <= s1_sum_d;
      s1_ovf_q   <= s1_ovf_d;
      fifo_cnt_q <= fifo_cnt_d;
      e0_sum_q   <= e0_sum_d;
      e0_ovf_q   <= e0_ovf_d;
      e1_sum_q   <= e1_sum_d;
      e1_ovf_q   <= e1_ovf_d;
      in_rdy_q   <= in_rdy_d;
      count_q    <= count_d;
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_vld  = (fifo_cnt_q != 2'd0);
  assign out_sum  = e0_sum_q;
  assign out_ovf  = e0_ovf_q;
  assign cp_idle  = ~s1_vld_q & (fifo_cnt_q == 2'd0);
  assign cp_count = count_q;

endmodule

// File: tb/tb_dadder_core.sv
// tb/tb_dadder_core.sv - directed self-checking bench for dadder_core
module tb_dadder_core;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, cp_en, cp_sat, cp_clr, cp_idle;
  logic [CW-1:0] cp_count;
  logic          in_vld, in_rdy, out_vld, out_rdy, out_ovf;
  logic [DW-1:0] in_a, in_b, out_sum;

  int tests = 0;
  int fails = 0;

  dadder_core #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .cp_en(cp_en), .cp_sat(cp_sat), .cp_clr(cp_clr),
    .cp_idle(cp_idle), .cp_count(cp_count), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_a(in_a), .in_b(in_b), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_ops(input int n);
    int  sent = 0;
    int  cyc  = 0;
    logic acc;
    out_rdy = 1'b1;
    while ((sent < n || !cp_idle) && cyc < 2 * n + 20) begin
      in_vld = (sent < n);
      in_a   = sent;
      in_b   = 32'd1;
      acc    = in_vld & in_rdy;
      step();
      if (acc) sent++;
      cyc++;
    end
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    if (sent < n || !cp_idle) begin
      tests++; fails++;
      $display("FAIL push_ops_timeout: sent %0d of %0d, idle %0b", sent, n, cp_idle);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; cp_en = 1'b1; cp_sat = 1'b0; cp_clr = 1'b0;
    in_vld = 1'b0; in_a = '0; in_b = '0; out_rdy = 1'b0;
    repeat (2) step();
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL reset_in_rdy: got %0b want 0", in_rdy); end
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL reset_out_vld: got %0b want 0", out_vld); end
    tests++; if (out_sum !== 32'd0) begin fails++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
    tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_out_ovf: got %0b want 0", out_ovf); end
    tests++; if (cp_idle !== 1'b1) begin fails++; $display("FAIL reset_cp_idle: got %0b want 1", cp_idle); end
    tests++; if (cp_count !== 8'd0) begin fails++; $display("FAIL reset_cp_count: got %0d want 0", cp_count); end
    reset = 1'b0;
    step();
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy_rise: got %0b want 1", in_rdy); end
  endtask

  task automatic test_single;
    in_a = 32'd5; in_b = 32'd7; in_vld = 1'b1;
    step();
    in_vld = 1'b0;
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL single_t1_vld: got %0b want 0", out_vld); end
    tests++; if (cp_idle !== 1'b0) begin fails++; $display("FAIL single_busy: got %0b want 0", cp_idle); end
    step();
    tests++; if (out_vld !== 1'b1) begin fails++; $display("FAIL single_t2_vld: got %0b want 1", out_vld); end
    tests++; if (out_sum !== 32'd12 || out_ovf !== 1'b0) begin fails++; $display("FAIL single_sum: got %0d/%0b want 12/0", out_sum, out_ovf); end
    step();
    tests++; if (out_vld !== 1'b1 || out_sum !== 32'd12) begin fails++; $display("FAIL single_stable: got %0b/%0d want 1/12", out_vld, out_sum); end
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    tests++; if (cp_count !== 8'd1) begin fails++; $display("FAIL single_count: got %0d want 1", cp_count); end
    tests++; if (out_vld !== 1'b0 || out_sum !== 32'd12) begin fails++; $display("FAIL single_hold: got %0b/%0d want 0/12", out_vld, out_sum); end
    tests++; if (cp_idle !== 1'b1) begin fails++; $display("FAIL single_idle: got %0b want 1", cp_idle); end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] exp_sat;
`ifdef DADDER_CORE_SAT_EN
    exp_sat = 32'hFFFF_FFFF;
`else
    exp_sat = 32'h0000_0001;
`endif
    in_a = 32'hFFFF_FFFF; in_b = 32'd2; cp_sat = 1'b1; in_vld = 1'b1; out_rdy = 1'b1;
    step();
    cp_sat = 1'b0;
    step();
    in_vld = 1'b0;
    tests++; if (out_vld !== 1'b1 || out_sum !== exp_sat || out_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sat: got %0b/%h/%0b want 1/%h/1", out_vld, out_sum, out_ovf, exp_sat); end
    step();
    tests++; if (out_vld !== 1'b1 || out_sum !== 32'd1 || out_ovf !== 1'b1) begin fails++; $display("FAIL ovf_wrap: got %0b/%h/%0b want 1/1/1", out_vld, out_sum, out_ovf); end
    step();
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL ovf_drain: got %0b want 0", out_vld); end
    out_rdy = 1'b0;
  endtask

  task automatic test_backpressure;
    int   acc = 0;
    logic ok;
    out_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_vld = 1'b1; in_a = 10 + acc; in_b = 32'd100;
      ok = in_rdy;
      step();
      if (ok) acc++;
    end
    in_vld = 1'b0;
    tests++; if (acc != 3) begin fails++; $display("FAIL bp_accepts: got %0d want 3", acc); end
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL bp_in_rdy_low: got %0b want 0", in_rdy); end
    out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests++; if (out_vld !== 1'b1 || out_sum !== 32'(110 + k)) begin fails++; $display("FAIL bp_order_%0d: got %0b/%0d want 1/%0d", k, out_vld, out_sum, 110 + k); end
      tests++; if (in_rdy !== (k != 0)) begin fails++; $display("FAIL bp_in_rdy_%0d: got %0b want %0b", k, in_rdy, k != 0); end
      step();
    end
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL bp_empty: got %0b want 0", out_vld); end
    out_rdy = 1'b0;
  endtask

  task automatic test_back_to_back;
    int   sent = 0, recv = 0, gaps = 0, stalls = 0, cyc = 0;
    logic acc;
    logic [DW:0] exp_full;
    cp_clr = 1'b1;
    step();
    cp_clr = 1'b0;
    tests++; if (cp_count !== 8'd0) begin fails++; $display("FAIL stream_clr: got %0d want 0", cp_count); end
    out_rdy = 1'b1;
    while (recv < 100 && cyc < 300) begin
      in_vld = (sent < 100);
      in_a   = 32'hFFFF_FFC0 + sent;
      in_b   = sent * 7;
      acc    = in_vld & in_rdy;
      if (in_vld && !in_rdy && sent > 0) stalls++;
      if (out_vld) begin
        exp_full = {1'b0, 32'hFFFF_FFC0 + 32'(recv)} + {1'b0, 32'(recv * 7)};
        tests++; if (out_sum !== exp_full[DW-1:0] || out_ovf !== exp_full[DW]) begin fails++; $display("FAIL stream_item_%0d: got %h/%0b want %h/%0b", recv, out_sum, out_ovf, exp_full[DW-1:0], exp_full[DW]); end
        recv++;
      end else if (recv > 0) begin
        gaps++;
      end
      step();
      if (acc) sent++;
      cyc++;
    end
    in_vld = 1'b0; out_rdy = 1'b0;
    tests++; if (recv != 100) begin fails++; $display("FAIL stream_timeout: got %0d results want 100", recv); end
    tests++; if (gaps != 0 || stalls != 0) begin fails++; $display("FAIL stream_rate: got %0d gaps %0d stalls want 0/0", gaps, stalls); end
    tests++; if (cp_count !== 8'd100) begin fails++; $display("FAIL stream_count: got %0d want 100", cp_count); end
    tests++; if (cp_idle !== 1'b1) begin fails++; $display("FAIL stream_idle: got %0b want 1", cp_idle); end
  endtask

  task automatic test_counter_edges;
    cp_clr = 1'b1;
    step();
    cp_clr = 1'b0;
    push_ops(255);
    tests++; if (cp_count !== 8'hFF) begin fails++; $display("FAIL cnt_max: got %0d want 255", cp_count); end
    push_ops(1);
    tests++; if (cp_count !== 8'd0) begin fails++; $display("FAIL cnt_wrap: got %0d want 0", cp_count); end
    push_ops(1);
    tests++; if (cp_count !== 8'd1) begin fails++; $display("FAIL cnt_one: got %0d want 1", cp_count); end
    in_vld = 1'b1; in_a = 32'd9; in_b = 32'd9;
    step();
    in_vld = 1'b0;
    step();
    tests++; if (out_vld !== 1'b1 || out_sum !== 32'd18) begin fails++; $display("FAIL cnt_pending: got %0b/%0d want 1/18", out_vld, out_sum); end
    out_rdy = 1'b1; cp_clr = 1'b1;
    step();
    out_rdy = 1'b0; cp_clr = 1'b0;
    tests++; if (cp_count !== 8'd0) begin fails++; $display("FAIL cnt_clr_wins: got %0d want 0", cp_count); end
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL cnt_clr_popped: got %0b want 0", out_vld); end
  endtask

  task automatic test_cp_en_drop;
    out_rdy = 1'b0;
    in_vld = 1'b1; in_a = 32'd1; in_b = 32'd2;
    step();
    in_a = 32'd3; in_b = 32'd4;
    step();
    in_vld = 1'b0; cp_en = 1'b0;
    step();
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL en_in_rdy: got %0b want 0", in_rdy); end
    tests++; if (out_vld !== 1'b1 || out_sum !== 32'd3) begin fails++; $display("FAIL en_first: got %0b/%0d want 1/3", out_vld, out_sum); end
    out_rdy = 1'b1;
    step();
    tests++; if (out_vld !== 1'b1 || out_sum !== 32'd7) begin fails++; $display("FAIL en_second: got %0b/%0d want 1/7", out_vld, out_sum); end
    step();
    tests++; if (cp_idle !== 1'b1 || out_vld !== 1'b0 || in_rdy !== 1'b0) begin fails++; $display("FAIL en_drained: got idle %0b vld %0b rdy %0b want 1/0/0", cp_idle, out_vld, in_rdy); end
    out_rdy = 1'b0; cp_en = 1'b1;
    step();
  endtask

  task automatic test_reset_midflight;
    out_rdy = 1'b0;
    in_vld = 1'b1; in_a = 32'd20; in_b = 32'd22;
    repeat (3) step();
    in_vld = 1'b0;
    tests++; if (out_vld !== 1'b1 || cp_idle !== 1'b0 || cp_count === 8'd0) begin fails++; $display("FAIL rst_pre: got vld %0b idle %0b cnt %0d want 1/0/nonzero", out_vld, cp_idle, cp_count); end
    reset = 1'b1;
    step();
    tests++; if (out_vld !== 1'b0 || cp_idle !== 1'b1 || cp_count !== 8'd0) begin fails++; $display("FAIL rst_mid: got vld %0b idle %0b cnt %0d want 0/1/0", out_vld, cp_idle, cp_count); end
    tests++; if (in_rdy !== 1'b0 || out_sum !== 32'd0 || out_ovf !== 1'b0) begin fails++; $display("FAIL rst_mid_out: got rdy %0b sum %0d ovf %0b want 0/0/0", in_rdy, out_sum, out_ovf); end
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_counter_edges();
    test_cp_en_drop();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
